// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined barrel shifter: opcode enum,
// opcode classification and a width-generic bit reversal.
package shift_pkg;

    typedef enum logic [2:0] {
        SLL = 3'b000,
        SRL = 3'b001,
        SRA = 3'b010,
        ROL = 3'b011,
        ROR = 3'b100
    } shift_op_e;

    localparam int DEF_WIDTH = 32;
    localparam int AMT_W     = $clog2(DEF_WIDTH);

    function automatic logic is_legal_op(input shift_op_e op);
        return (op <= ROR);
    endfunction

    // Left operations run through the right-shift core on bit-reversed data.
    function automatic logic is_left_op(input shift_op_e op);
        return (op == SLL) || (op == ROL);
    endfunction

    // Reverses the low w bits of x; bits at w and above come back as zero.
    function automatic logic [63:0] bit_rev(input logic [63:0] x, input int unsigned w);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) begin
            r[i] = x[63-i];
        end
        return r >> (64 - w);
    endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// Valid/ready operand and result bus of shift_pipe; slave is the shifter side.
interface shift_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    import shift_pkg::*;

    localparam int AW = $clog2(WIDTH);

    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data;
    logic [AW-1:0]    i_amount;
    shift_op_e        i_op;
    logic [TAG_W-1:0] i_tag;

    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_result;
    logic [TAG_W-1:0] o_tag;
    logic             o_illegal;

    modport slave (
        input  i_valid, i_data, i_amount, i_op, i_tag, i_ready,
        output o_ready, o_valid, o_result, o_tag, o_illegal
    );

    modport master (
        output i_valid, i_data, i_amount, i_op, i_tag, i_ready,
        input  o_ready, o_valid, o_result, o_tag, o_illegal
    );

endinterface

// File: rtl/shift_stage.sv
// One pipeline stage: NUM_LVL right-shift mux levels starting at FIRST_LVL,
// followed by the stage register with its valid/advance control.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int AMT_W     = 5,
    parameter int TAG_W     = 5,
    parameter int FIRST_LVL = 0,
    parameter int NUM_LVL   = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic [AMT_W-1:0] i_amount,
    input  shift_op_e        i_op,
    input  logic             i_sign,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_adv_down,
    output logic             o_adv,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [AMT_W-1:0] o_amount,
    output shift_op_e        o_op,
    output logic             o_sign,
    output logic [TAG_W-1:0] o_tag
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [AMT_W-1:0] r_amount;
    shift_op_e        r_op;
    logic             r_sign;
    logic [TAG_W-1:0] r_tag;
    logic [WIDTH-1:0] w_final;

    genvar gi;
    for (gi = 0; gi < NUM_LVL; gi++) begin : g_lvl
        localparam int LVL = FIRST_LVL + gi;
        localparam int SH  = WIDTH >> (LVL + 1);

        logic [WIDTH-1:0] w_in;
        logic [WIDTH-1:0] w_out;
        logic [WIDTH-1:0] w_shr;
        logic [WIDTH-1:0] w_mask;
        logic [WIDTH-1:0] w_fill;

        if (gi == 0) begin : g_src
            assign w_in = i_data;
        end else begin : g_src
            assign w_in = g_lvl[gi-1].w_out;
        end

        assign w_shr  = w_in >> SH;
        assign w_mask = ~({WIDTH{1'b1}} >> SH);

        // Vacated top SH bits: sign copies for SRA, wrapped low bits for rotates.
        always_comb begin
            w_fill = '0;
            case (i_op)
                SRA:      w_fill = w_mask & {WIDTH{i_sign}};
                ROL, ROR: w_fill = w_in << (WIDTH - SH);
                default:  w_fill = '0;
            endcase
        end

        assign w_out = i_amount[AMT_W-1-LVL] ? (w_shr | w_fill) : w_in;
    end

    assign w_final = g_lvl[NUM_LVL-1].w_out;

    // An empty stage always loads, which collapses bubbles under a stall.
    assign o_adv = !r_valid || i_adv_down;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_amount <= '0;
            r_op     <= SLL;
            r_sign   <= 1'b0;
            r_tag    <= '0;
        end else if (o_adv) begin
            r_valid  <= i_valid;
            r_data   <= w_final;
            r_amount <= i_amount;
            r_op     <= i_op;
            r_sign   <= i_sign;
            r_tag    <= i_tag;
        end
    end

    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_amount = r_amount;
    assign o_op     = r_op;
    assign o_sign   = r_sign;
    assign o_tag    = r_tag;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) built on one right-shift core,
// with log2(WIDTH) mux levels spread over PIPE_STAGES valid/ready stages.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 5
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    shift_pipe_if.slave  bus
);

    localparam int L = $clog2(WIDTH);

    logic [63:0]      w_rev_in64;
    logic [WIDTH-1:0] w_entry_data;

    assign w_rev_in64   = bit_rev(64'(bus.i_data), WIDTH);
    assign w_entry_data = is_left_op(bus.i_op) ? w_rev_in64[WIDTH-1:0] : bus.i_data;

    genvar gi;
    for (gi = 0; gi < PIPE_STAGES; gi++) begin : g_stg
        // Level k lands in stage floor(k*PIPE_STAGES/L).
        localparam int FIRST = (gi * L + PIPE_STAGES - 1) / PIPE_STAGES;
        localparam int NEXT  = ((gi + 1) * L + PIPE_STAGES - 1) / PIPE_STAGES;

        logic             w_in_valid;
        logic [WIDTH-1:0] w_in_data;
        logic [L-1:0]     w_in_amount;
        shift_op_e        w_in_op;
        logic             w_in_sign;
        logic [TAG_W-1:0] w_in_tag;
        logic             w_adv_down;
        logic             w_adv;
        logic             w_valid;
        logic [WIDTH-1:0] w_data;
        logic [L-1:0]     w_amount;
        shift_op_e        w_op;
        logic             w_sign;
        logic [TAG_W-1:0] w_tag;

        if (gi == 0) begin : g_src
            assign w_in_valid  = bus.i_valid;
            assign w_in_data   = w_entry_data;
            assign w_in_amount = bus.i_amount;
            assign w_in_op     = bus.i_op;
            assign w_in_sign   = bus.i_data[WIDTH-1];
            assign w_in_tag    = bus.i_tag;
        end else begin : g_src
            assign w_in_valid  = g_stg[gi-1].w_valid;
            assign w_in_data   = g_stg[gi-1].w_data;
            assign w_in_amount = g_stg[gi-1].w_amount;
            assign w_in_op     = g_stg[gi-1].w_op;
            assign w_in_sign   = g_stg[gi-1].w_sign;
            assign w_in_tag    = g_stg[gi-1].w_tag;
        end

        if (gi == PIPE_STAGES - 1) begin : g_dst
            assign w_adv_down = bus.i_ready;
        end else begin : g_dst
            assign w_adv_down = g_stg[gi+1].w_adv;
        end

        shift_stage #(
            .WIDTH     (WIDTH),
            .AMT_W     (L),
            .TAG_W     (TAG_W),
            .FIRST_LVL (FIRST),
            .NUM_LVL   (NEXT - FIRST)
        ) u_stage (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_valid    (w_in_valid),
            .i_data     (w_in_data),
            .i_amount   (w_in_amount),
            .i_op       (w_in_op),
            .i_sign     (w_in_sign),
            .i_tag      (w_in_tag),
            .i_adv_down (w_adv_down),
            .o_adv      (w_adv),
            .o_valid    (w_valid),
            .o_data     (w_data),
            .o_amount   (w_amount),
            .o_op       (w_op),
            .o_sign     (w_sign),
            .o_tag      (w_tag)
        );
    end

    shift_op_e        w_last_op;
    logic [WIDTH-1:0] w_last_data;
    logic [63:0]      w_rev_out64;
    logic             w_last_legal;
    logic             w_unused_tail;

    assign w_last_op     = g_stg[PIPE_STAGES-1].w_op;
    assign w_last_data   = g_stg[PIPE_STAGES-1].w_data;
    assign w_last_legal  = is_legal_op(w_last_op);
    assign w_rev_out64   = bit_rev(64'(w_last_data), WIDTH);
    assign w_unused_tail = ^{g_stg[PIPE_STAGES-1].w_amount, g_stg[PIPE_STAGES-1].w_sign};

    assign bus.o_ready   = g_stg[0].w_adv;
    assign bus.o_valid   = g_stg[PIPE_STAGES-1].w_valid;
    assign bus.o_tag     = g_stg[PIPE_STAGES-1].w_tag;
    assign bus.o_illegal = g_stg[PIPE_STAGES-1].w_valid && !w_last_legal;
    assign bus.o_result  = !w_last_legal          ? '0 :
                           is_left_op(w_last_op)  ? w_rev_out64[WIDTH-1:0] :
                                                    w_last_data;

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe in three configurations (32/2, 8/3, 64/1).
module tb_shift_pipe;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_pipe_if #(.WIDTH(32), .TAG_W(5)) ifa ();
    shift_pipe_if #(.WIDTH(8),  .TAG_W(5)) ifb ();
    shift_pipe_if #(.WIDTH(64), .TAG_W(5)) ifc ();

    shift_pipe #(.WIDTH(32), .PIPE_STAGES(2), .TAG_W(5)) u_a (.i_clk(clk), .i_rst_n(rst_n), .bus(ifa));
    shift_pipe #(.WIDTH(8),  .PIPE_STAGES(3), .TAG_W(5)) u_b (.i_clk(clk), .i_rst_n(rst_n), .bus(ifb));
    shift_pipe #(.WIDTH(64), .PIPE_STAGES(1), .TAG_W(5)) u_c (.i_clk(clk), .i_rst_n(rst_n), .bus(ifc));

    typedef struct {
        int          dut;
        logic [63:0] res;
        logic [4:0]  tag;
        logic        ill;
        int          acc_cyc;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic [4:0]  amt;
        logic [4:0]  tag;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];

    logic        dv_valid[3];
    logic [63:0] dv_data[3];
    logic [5:0]  dv_amt[3];
    logic [2:0]  dv_op[3];
    logic [4:0]  dv_tag[3];
    logic        dv_ready[3];
    logic [63:0] dv_exp[3];
    logic        dv_ill[3];

    logic        acc[3];
    logic        rdy[3];
    logic        ov[3];
    logic        oill[3];
    logic [63:0] ores[3];
    logic [4:0]  otag[3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_lat = 1'b1;

    function automatic int dut_w(int d);
        return (d == 0) ? 32 : (d == 1) ? 8 : 64;
    endfunction

    function automatic int dut_p(int d);
        return (d == 0) ? 2 : (d == 1) ? 3 : 1;
    endfunction

    function automatic logic [63:0] wmask(int w);
        return (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    // Bit-by-bit statement of each operation; reserved codes give zero.
    function automatic logic [63:0] model(int w, logic [2:0] op, logic [63:0] d, int amt);
        logic [63:0] r = '0;
        if (op > 3'd4) return '0;
        for (int i = 0; i < w; i++) begin
            case (op)
                3'd0:    r[i] = (i >= amt) ? d[i-amt] : 1'b0;
                3'd1:    r[i] = (i + amt < w) ? d[i+amt] : 1'b0;
                3'd2:    r[i] = (i + amt < w) ? d[i+amt] : d[w-1];
                3'd3:    r[(i+amt)%w] = d[i];
                default: r[i] = d[(i+amt)%w];
            endcase
        end
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_check(int d);
        int   idx = -1;
        exp_t e;
        foreach (sb[i]) if (idx < 0 && sb[i].dut == d) idx = i;
        if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out dut%0d: got result %h tag %h, expected no output", d, ores[d], otag[d]);
            return;
        end
        e = sb[idx];
        sb.delete(idx);
        check($sformatf("result dut%0d tag %h", d, e.tag), ores[d], e.res);
        check($sformatf("tag dut%0d", d), 64'(otag[d]), 64'(e.tag));
        check($sformatf("illegal dut%0d tag %h", d, e.tag), 64'(oill[d]), 64'(e.ill));
        if (chk_lat) check($sformatf("latency dut%0d tag %h", d, e.tag), 64'(cyc - e.acc_cyc), 64'(dut_p(d)));
        $display("dut%0d cycle %0d tag %h result %h illegal %0d", d, cyc, otag[d], ores[d], oill[d]);
    endtask

    // One clock: drive at the falling edge, observe 1ns later, score the handshakes.
    task automatic cycle();
        @(negedge clk);
        ifa.i_valid = dv_valid[0]; ifa.i_data = dv_data[0][31:0]; ifa.i_amount = dv_amt[0][4:0];
        ifa.i_op = shift_op_e'(dv_op[0]); ifa.i_tag = dv_tag[0]; ifa.i_ready = dv_ready[0];
        ifb.i_valid = dv_valid[1]; ifb.i_data = dv_data[1][7:0]; ifb.i_amount = dv_amt[1][2:0];
        ifb.i_op = shift_op_e'(dv_op[1]); ifb.i_tag = dv_tag[1]; ifb.i_ready = dv_ready[1];
        ifc.i_valid = dv_valid[2]; ifc.i_data = dv_data[2]; ifc.i_amount = dv_amt[2];
        ifc.i_op = shift_op_e'(dv_op[2]); ifc.i_tag = dv_tag[2]; ifc.i_ready = dv_ready[2];
        #1;
        rdy[0] = ifa.o_ready; ov[0] = ifa.o_valid; ores[0] = 64'(ifa.o_result); otag[0] = ifa.o_tag; oill[0] = ifa.o_illegal;
        rdy[1] = ifb.o_ready; ov[1] = ifb.o_valid; ores[1] = 64'(ifb.o_result); otag[1] = ifb.o_tag; oill[1] = ifb.o_illegal;
        rdy[2] = ifc.o_ready; ov[2] = ifc.o_valid; ores[2] = ifc.o_result;      otag[2] = ifc.o_tag; oill[2] = ifc.o_illegal;
        for (int d = 0; d < 3; d++) begin
            exp_t e;
            if (ov[d] && dv_ready[d]) pop_check(d);
            acc[d] = dv_valid[d] && rdy[d];
            if (acc[d]) begin
                e.dut = d; e.res = dv_exp[d]; e.tag = dv_tag[d]; e.ill = dv_ill[d]; e.acc_cyc = cyc;
                sb.push_back(e);
            end
        end
        cyc++;
    endtask

    task automatic set_item(int d, logic [2:0] op, logic [63:0] data, int amt, logic [4:0] tag,
                            logic [63:0] exp, logic ill);
        dv_valid[d] = 1'b1; dv_op[d] = op; dv_data[d] = data; dv_amt[d] = 6'(amt);
        dv_tag[d] = tag; dv_exp[d] = exp; dv_ill[d] = ill;
    endtask

    task automatic set_modelled(int d, logic [2:0] op, int amt, logic [4:0] tag);
        int          w = dut_w(d);
        logic [63:0] data = {$urandom, $urandom} & wmask(w);
        set_item(d, op, data, amt, tag, model(w, op, data, amt), op > 3'd4);
    endtask

    task automatic set_rand(int d, logic [4:0] tag);
        set_modelled(d, 3'($urandom_range(0, 7)), $urandom_range(0, dut_w(d) - 1), tag);
    endtask

    task automatic wait_acc(int d, output int waits);
        waits = 0;
        do begin
            cycle();
            waits++;
        end while (!acc[d] && waits < 64);
        if (!acc[d]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut%0d: got no accept in %0d cycles, expected one", d, waits);
        end
        dv_valid[d] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 300) begin
            cycle();
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d items outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish within 1ms");
        $fatal(1, "timeout");
    end

    initial begin
        int          waits;
        int          n_acc;
        bit          held;
        logic [63:0] hold_res;
        logic [4:0]  hold_tag;

        for (int d = 0; d < 3; d++) begin
            dv_valid[d] = 1'b0; dv_data[d] = '0; dv_amt[d] = '0; dv_op[d] = '0;
            dv_tag[d] = '0; dv_ready[d] = 1'b1; dv_exp[d] = '0; dv_ill[d] = 1'b0;
        end

        vecs[0] = '{3'b000, 32'h0000_0001, 5'd31, 5'h01, 32'h8000_0000, 1'b0};
        vecs[1] = '{3'b010, 32'h8000_0000, 5'd4,  5'h02, 32'hF800_0000, 1'b0};
        vecs[2] = '{3'b001, 32'h8000_0000, 5'd4,  5'h03, 32'h0800_0000, 1'b0};
        vecs[3] = '{3'b100, 32'h0000_00F1, 5'd4,  5'h04, 32'h1000_000F, 1'b0};
        vecs[4] = '{3'b011, 32'h8000_0001, 5'd1,  5'h05, 32'h0000_0003, 1'b0};
        vecs[5] = '{3'b110, 32'h1234_5678, 5'd7,  5'h1A, 32'h0000_0000, 1'b1};
        vecs[6] = '{3'b010, 32'hDEAD_BEEF, 5'd0,  5'h06, 32'hDEAD_BEEF, 1'b0};

        // Reset state
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        check("reset_o_valid",   64'(ov[0]),   64'd0);
        check("reset_o_result",  ores[0],      64'd0);
        check("reset_o_tag",     64'(otag[0]), 64'd0);
        check("reset_o_illegal", 64'(oill[0]), 64'd0);
        check("reset_o_ready",   64'(rdy[0]),  64'd1);

        // Directed vectors, back to back
        foreach (vecs[i]) begin
            set_item(0, vecs[i].op, 64'(vecs[i].data), int'(vecs[i].amt), vecs[i].tag,
                     64'(vecs[i].res), vecs[i].ill);
            wait_acc(0, waits);
        end
        drain();

        // Random stream: o_ready must stay high, one accept per cycle
        for (int i = 0; i < 16; i++) begin
            set_rand(0, 5'(i));
            wait_acc(0, waits);
            check($sformatf("stream_ready item %0d", i), 64'(waits), 64'd1);
        end
        drain();

        // Downstream stall for 5 cycles while feeding
        chk_lat = 1'b0;
        dv_ready[0] = 1'b0;
        n_acc = 0;
        held = 1'b0;
        hold_res = '0;
        hold_tag = '0;
        set_rand(0, 5'h10);
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (acc[0]) begin
                n_acc++;
                set_rand(0, 5'(5'h10 + n_acc));
            end
            if (ov[0]) begin
                if (held) begin
                    check("stall_result_stable", ores[0], hold_res);
                    check("stall_tag_stable", 64'(otag[0]), 64'(hold_tag));
                end
                held = 1'b1;
                hold_res = ores[0];
                hold_tag = otag[0];
            end
        end
        check("stall_accepts", 64'(n_acc), 64'd2);
        check("stall_ready_low", 64'(rdy[0]), 64'd0);
        dv_valid[0] = 1'b0;
        dv_ready[0] = 1'b1;
        drain();
        chk_lat = 1'b1;

        // Asynchronous reset with two items in flight
        set_rand(0, 5'h11);
        wait_acc(0, waits);
        set_rand(0, 5'h12);
        wait_acc(0, waits);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_o_valid", 64'(ifa.o_valid), 64'd0);
        sb.delete();
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check($sformatf("post_rst_valid cycle %0d", k), 64'(ov[0]), 64'd0);
            check($sformatf("post_rst_ready cycle %0d", k), 64'(rdy[0]), 64'd1);
        end

        // Exhaustive amounts for every legal op on the 8/3 and 64/1 configurations
        for (int d = 1; d < 3; d++) begin
            for (int op = 0; op < 5; op++) begin
                for (int amt = 0; amt < dut_w(d); amt++) begin
                    set_modelled(d, 3'(op), amt, 5'(amt));
                    wait_acc(d, waits);
                end
            end
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter with five operations: SLL, SRL, SRA, ROL and ROR.
- Uses a valid/ready handshake and carries a tag through the pipeline alongside each operand.
- Serves as the shared shift unit for the multi-cycle execute path and replaces the single-purpose combinational left shifter.
- Log2(WIDTH) mux levels are spread across PIPE_STAGES register stages. The pipeline supports stalls and bubble collapsing.

Parameters:
- WIDTH, 32: operand width. Must be a power of 2, range 8..64.
- PIPE_STAGES, 2: number of register stages, range 1..log2(WIDTH). This is also the latency in cycles.
- TAG_W, 5: width of the sideband tag (for example the rd index), passed through unchanged.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input operand valid.
- o_ready  out  1  input accepted when i_valid && o_ready.
- i_data  in  WIDTH  operand.
- i_amount  in  log2(WIDTH)  shift/rotate amount, unsigned.
- i_op  in  3  operation code of type shift_op_e.
- i_tag  in  TAG_W  sideband tag.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts when o_valid && i_ready.
- o_result  out  WIDTH  shifted/rotated result.
- o_tag  out  TAG_W  tag of the result.
- o_illegal  out  1  reserved opcode flag, qualified by o_valid.

Behaviour:
- Reset: all stage valid bits cleared. o_valid=0, o_result=0, o_tag=0, o_illegal=0.
  - o_ready=1 after reset, since the pipeline is empty.
  - Reset asserted mid-operation discards all in-flight items; no partial result is ever presented.
- Opcodes (shift_op_e):
  - SLL=3'b000: zero fill from the LSB end.
  - SRL=3'b001: zero fill from the MSB end.
  - SRA=3'b010: fill with i_data[WIDTH-1].
  - ROL=3'b011, ROR=3'b100: bits shifted out re-enter at the opposite end.
  - 3'b101..3'b111 are reserved: o_result=0, o_illegal=1, tag still passed through.
- Amount: taken modulo WIDTH by port width. Amount 0 returns i_data unchanged for every legal op.
- Datapath: a single right-shift core.
  - Left ops bit-reverse the operand at entry and the result at exit.
  - Fill source per level: 0 for logical, the sign bit (captured at entry) for SRA, the wrapped bits for rotates.
  - Mux levels are ordered by amount bit, MSB first (WIDTH/2 shift first, 1-bit shift last).
  - Level k (k=0..L-1, L=log2(WIDTH)) is placed in stage floor(k*PIPE_STAGES/L).
  - Each stage ends in a register holding: partial data, remaining amount bits, op, sign bit, tag, valid.
- Latency: an item accepted in cycle t appears with o_valid=1 in cycle t+PIPE_STAGES if no stall occurs.
- Flow control, per stage s (last stage = output):
  - advance_s = !valid_s || advance_(s+1). For the last stage, advance = !valid_last || i_ready.
  - When advance_s is true, stage s loads from stage s-1 (or from the inputs for s=0) and takes that stage's valid.
  - When advance_s is false, stage s holds its data and valid.
  - o_ready = advance_0. This is combinational from i_ready, and the path is acceptable.
- Bubble collapsing: an empty stage always loads, even while downstream is stalled. Throughput is one item per cycle when i_ready is held high.
- Outputs stay stable while o_valid && !i_ready. No item may be dropped or duplicated.
- Simultaneous accept and emit in the same cycle is allowed when the pipeline is full and i_ready=1.
- Ordering is strictly FIFO.

Decomposition:
- shift_pkg holds:
  - the shift_op_e enum with the codes above;
  - the function is_legal_op;
  - localparam AMT_W = $clog2(WIDTH), passed in as a parameter at instantiation;
  - the bit-reverse function.
- Sub-module shift_stage is instantiated PIPE_STAGES times. Its parameters are the first level index and the level count. It contains the combinational mux levels plus the stage register and the valid/advance logic.

Test Plan:
- WIDTH=32, PIPE_STAGES=2, i_ready=1. Send in turn:
  - SLL 0x0000_0001 by 31 -> 0x8000_0000.
  - SRA 0x8000_0000 by 4 -> 0xF800_0000.
  - SRL 0x8000_0000 by 4 -> 0x0800_0000.
  - ROR 0x0000_00F1 by 4 -> 0x1000_000F.
  - ROL 0x8000_0001 by 1 -> 0x0000_0003.
  - Each result appears exactly 2 cycles after acceptance with the matching tag.
- Back-to-back stream of 16 random ops with i_ready=1 -> one result per cycle, in order, all matching the reference model. o_ready never drops.
- Hold i_ready=0 for 5 cycles while feeding items -> pipeline fills, o_ready falls after PIPE_STAGES accepts, o_result/o_tag stay stable. On release, items drain in order with none lost.
- i_op=3'b110, tag 5'h1A -> o_valid with o_result=0, o_illegal=1, o_tag=5'h1A. Amount 0 with SRA of 0xDEAD_BEEF -> 0xDEAD_BEEF.
- Assert i_rst_n=0 asynchronously mid-cycle with 2 items in flight -> o_valid=0 immediately. After release, no stale results appear, and o_ready=1.
- Sweep configurations (WIDTH=8, PIPE_STAGES=3) and (WIDTH=64, PIPE_STAGES=1). Exhaustive amounts for all ops on random data -> match the model. Latency equals PIPE_STAGES.
